// File: rtl/md5_compress_ctrl.sv
// MD5 compression sequencer: 64 steps at one per clock through four combinational
// step units, followed by the chaining add.

// Round 1 step unit: F(b,c,d) = (b & c) | (~b & d), message word i.
module round1 (
  input  logic [511:0] indata,
  input  logic [3:0]   in_round,
  input  logic [127:0] link_var,
  output logic [31:0]  result
);
  localparam logic [31:0] K [16] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821};
  localparam logic [4:0] S [4] = '{5'd7, 5'd12, 5'd17, 5'd22};

  logic [31:0] a, b, c, d, f, m, sum;
  logic [63:0] rot;

  // rotl(a + F + M + K, s); the rotate is the upper half of a doubled shift
  always_comb begin
    {d, c, b, a} = link_var;
    f      = (b & c) | (~b & d);
    m      = indata[{in_round, 5'd0} +: 32];
    sum    = a + f + m + K[in_round];
    rot    = {sum, sum} << S[in_round[1:0]];
    result = rot[63:32];
  end
endmodule

// Round 2 step unit: G(b,c,d) = (b & d) | (c & ~d), message word (5i+1) mod 16.
module round2 (
  input  logic [511:0] indata,
  input  logic [3:0]   in_round,
  input  logic [127:0] link_var,
  output logic [31:0]  result
);
  localparam logic [31:0] K [16] = '{
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a};
  localparam logic [4:0] S [4] = '{5'd5, 5'd9, 5'd14, 5'd20};

  logic [31:0] a, b, c, d, f, m, sum;
  logic [3:0]  g;
  logic [63:0] rot;

  // rotl(a + G + M[g] + K, s)
  always_comb begin
    {d, c, b, a} = link_var;
    f      = (b & d) | (c & ~d);
    g      = 4'(4'd5 * in_round + 4'd1);
    m      = indata[{g, 5'd0} +: 32];
    sum    = a + f + m + K[in_round];
    rot    = {sum, sum} << S[in_round[1:0]];
    result = rot[63:32];
  end
endmodule

// Round 3 step unit: H(b,c,d) = b ^ c ^ d, message word (3i+5) mod 16.
module round3 (
  input  logic [511:0] indata,
  input  logic [3:0]   in_round,
  input  logic [127:0] link_var,
  output logic [31:0]  result
);
  localparam logic [31:0] K [16] = '{
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665};
  localparam logic [4:0] S [4] = '{5'd4, 5'd11, 5'd16, 5'd23};

  logic [31:0] a, b, c, d, f, m, sum;
  logic [3:0]  g;
  logic [63:0] rot;

  // rotl(a + H + M[g] + K, s)
  always_comb begin
    {d, c, b, a} = link_var;
    f      = b ^ c ^ d;
    g      = 4'(4'd3 * in_round + 4'd5);
    m      = indata[{g, 5'd0} +: 32];
    sum    = a + f + m + K[in_round];
    rot    = {sum, sum} << S[in_round[1:0]];
    result = rot[63:32];
  end
endmodule

// Round 4 step unit: I(b,c,d) = c ^ (b | ~d), message word 7i mod 16.
module round4 (
  input  logic [511:0] indata,
  input  logic [3:0]   in_round,
  input  logic [127:0] link_var,
  output logic [31:0]  result
);
  localparam logic [31:0] K [16] = '{
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};
  localparam logic [4:0] S [4] = '{5'd6, 5'd10, 5'd15, 5'd21};

  logic [31:0] a, b, c, d, f, m, sum;
  logic [3:0]  g;
  logic [63:0] rot;

  // rotl(a + I + M[g] + K, s)
  always_comb begin
    {d, c, b, a} = link_var;
    f      = c ^ (b | ~d);
    g      = 4'(4'd7 * in_round);
    m      = indata[{g, 5'd0} +: 32];
    sum    = a + f + m + K[in_round];
    rot    = {sum, sum} << S[in_round[1:0]];
    result = rot[63:32];
  end
endmodule

module md5_compress_ctrl #(
  parameter int unsigned ADD_IV = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [511:0] indata,
  input  logic [127:0] iv,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [5:0]   step,
  output logic [127:0] digest
);
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLK_W   = 512;
  localparam int unsigned STATE_W = 4 * WORD_W;
  localparam int unsigned STEP_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [BLK_W-1:0]   blk_reg;
  logic [STATE_W-1:0] iv_reg;
  logic [WORD_W-1:0]  a_reg, b_reg, c_reg, d_reg;
  logic [WORD_W-1:0]  r1_res, r2_res, r3_res, r4_res, step_res_c;
  logic [STATE_W-1:0] link_c, final_c;
  logic               accept_c;

  assign link_c   = {d_reg, c_reg, b_reg, a_reg};
  assign accept_c = (state == IDLE) && start && !abort;

  round1 u_round1 (.indata(blk_reg), .in_round(step[3:0]), .link_var(link_c), .result(r1_res));
  round2 u_round2 (.indata(blk_reg), .in_round(step[3:0]), .link_var(link_c), .result(r2_res));
  round3 u_round3 (.indata(blk_reg), .in_round(step[3:0]), .link_var(link_c), .result(r3_res));
  round4 u_round4 (.indata(blk_reg), .in_round(step[3:0]), .link_var(link_c), .result(r4_res));

  // Pick the step unit for the current round
  always_comb begin
    step_res_c = r1_res;
    case (step[5:4])
      2'd0:    step_res_c = r1_res;
      2'd1:    step_res_c = r2_res;
      2'd2:    step_res_c = r3_res;
      default: step_res_c = r4_res;
    endcase
  end

  // Chaining add (or raw working state when the add is disabled)
  always_comb begin
    final_c = {d_reg, c_reg, b_reg, a_reg};
    if (ADD_IV != 0) begin
      final_c = {iv_reg[127:96] + d_reg, iv_reg[95:64] + c_reg,
                 iv_reg[63:32]  + b_reg, iv_reg[31:0]  + a_reg};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort always returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = RUN;
      RUN: begin
        if (abort)                      state_nxt = IDLE;
        else if (step == STEP_W'(63))   state_nxt = FINAL;
      end
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath, step counter and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      step    <= '0;
      digest  <= '0;
      blk_reg <= '0;
      iv_reg  <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      c_reg   <= '0;
      d_reg   <= '0;
    end else begin
      ready <= (state_nxt == IDLE);
      busy  <= (state_nxt != IDLE);
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            blk_reg <= indata;
            iv_reg  <= iv;
            a_reg   <= iv[31:0];
            b_reg   <= iv[63:32];
            c_reg   <= iv[95:64];
            d_reg   <= iv[127:96];
            step    <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            step <= '0;
          end else begin
            a_reg <= d_reg;
            d_reg <= c_reg;
            c_reg <= b_reg;
            b_reg <= b_reg + step_res_c;
            step  <= step + STEP_W'(1);
          end
        end
        FINAL: begin
          if (!abort) begin
            digest <= final_c;
            done   <= 1'b1;
          end
        end
        default: step <= '0;
      endcase
    end
  end
endmodule
